// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a two-entry skid buffer, synchronous flush
// and a saturating stall counter. in_ready is registered so out_ready never reaches it combinationally.
module pipe_stage_skid #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             accept;
  logic             deliver;

  assign accept   = in_valid & in_ready;
  assign deliver  = out_valid & out_ready;
  assign out_data = main_q;

  always_comb begin
    next_state = state;
    case (state)
      EMPTY: if (accept) next_state = ONE;
      ONE: begin
        if (accept && !deliver)      next_state = FULL;
        else if (!accept && deliver) next_state = EMPTY;
      end
      FULL:    if (deliver) next_state = ONE;
      default: next_state = EMPTY;
    endcase
    // Squash wins over everything; a same-cycle deliver has already been sampled downstream.
    if (flush) next_state = EMPTY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      out_valid <= 1'b0;
      occupancy <= 2'd0;
      in_ready  <= 1'b1;
      stall_cnt <= '0;
    end else begin
      state     <= next_state;
      in_ready  <= (next_state != FULL);
      out_valid <= (next_state != EMPTY);
      case (next_state)
        ONE:     occupancy <= 2'd1;
        FULL:    occupancy <= 2'd2;
        default: occupancy <= 2'd0;
      endcase

      // Data registers keep their old contents on flush; they are don't-care while out_valid=0.
      if (!flush) begin
        case (state)
          EMPTY: if (accept) main_q <= in_data;
          ONE: begin
            if (accept && deliver)  main_q <= in_data;
            if (accept && !deliver) skid_q <= in_data;
          end
          FULL:    if (deliver) main_q <= skid_q;
          default: ;
        endcase
      end

      if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule
